// File: rtl/raster_pkg.sv
// Shared raster-pipeline definitions: walker state encoding, default widths
// and the small edge-arithmetic helpers used by the per-pixel walker.
package raster_pkg;
    localparam int DEF_COORD_W = 10;
    localparam int DEF_COEFF_W = 16;
    localparam int DEF_EDGE_W  = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_FINISH = 2'd2
    } walk_state_e;

    function automatic logic [DEF_EDGE_W-1:0] sext_coeff(input logic [DEF_COEFF_W-1:0] c);
        return {{(DEF_EDGE_W-DEF_COEFF_W){c[DEF_COEFF_W-1]}}, c};
    endfunction

    // A pixel is covered when all three edge values are non-negative (sign bits clear).
    function automatic logic is_inside(input logic [DEF_EDGE_W-1:0] w0,
                                       input logic [DEF_EDGE_W-1:0] w1,
                                       input logic [DEF_EDGE_W-1:0] w2);
        return !(w0[DEF_EDGE_W-1] | w1[DEF_EDGE_W-1] | w2[DEF_EDGE_W-1]);
    endfunction
endpackage

// File: rtl/tile_pixel_walker_if.sv
// Tile-descriptor input stream and fragment output stream of the pixel walker.
interface tile_pixel_walker_if
    import raster_pkg::*;
#(
    parameter int COORD_W = DEF_COORD_W,
    parameter int COEFF_W = DEF_COEFF_W,
    parameter int EDGE_W  = DEF_EDGE_W
);
    // Both streams: a transfer happens on a rising edge where valid && ready;
    // the source holds its payload stable while valid && !ready.
    logic               tile_valid;
    logic               tile_ready;
    logic               tile_inside;
    logic [COORD_W-1:0] tile_x;
    logic [COORD_W-1:0] tile_y;
    logic [EDGE_W-1:0]  e0, e1, e2;
    logic [COEFF_W-1:0] a0, b0, a1, b1, a2, b2;
    logic               frag_valid;
    logic               frag_ready;
    logic [COORD_W-1:0] frag_x;
    logic [COORD_W-1:0] frag_y;
    logic [EDGE_W-1:0]  frag_w0, frag_w1, frag_w2;
    logic               tile_done;

    modport master (
        output tile_valid, tile_inside, tile_x, tile_y, e0, e1, e2,
               a0, b0, a1, b1, a2, b2, frag_ready,
        input  tile_ready, frag_valid, frag_x, frag_y,
               frag_w0, frag_w1, frag_w2, tile_done
    );

    modport slave (
        input  tile_valid, tile_inside, tile_x, tile_y, e0, e1, e2,
               a0, b0, a1, b1, a2, b2, frag_ready,
        output tile_ready, frag_valid, frag_x, frag_y,
               frag_w0, frag_w1, frag_w2, tile_done
    );
endinterface

// File: rtl/edge_stepper.sv
// One edge function walked incrementally: row start value plus current pixel
// value, stepped by the captured x/y coefficients.
module edge_stepper #(
    parameter int EDGE_W = raster_pkg::DEF_EDGE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              step_x_i,
    input  logic              step_row_i,
    input  logic [EDGE_W-1:0] e_i,
    input  logic [EDGE_W-1:0] a_i,
    input  logic [EDGE_W-1:0] b_i,
    output logic [EDGE_W-1:0] cur_o
);
    logic [EDGE_W-1:0] a_q, a_d, b_q, b_d;
    logic [EDGE_W-1:0] row_q, row_d, cur_q, cur_d;

    // Coefficients are captured with the origin value so upstream may move on.
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        row_d = row_q;
        cur_d = cur_q;
        if (load_i) begin
            a_d   = a_i;
            b_d   = b_i;
            row_d = e_i;
            cur_d = e_i;
        end else if (step_row_i) begin
            row_d = row_q + b_q;
            cur_d = row_q + b_q;
        end else if (step_x_i) begin
            cur_d = cur_q + a_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q   <= '0;
            b_q   <= '0;
            row_q <= '0;
            cur_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            row_q <= row_d;
            cur_q <= cur_d;
        end
    end

    assign cur_o = cur_q;
endmodule

// File: rtl/tile_pixel_walker.sv
// Walks the T x T pixels of an accepted tile in raster order, one per cycle,
// and emits every covered pixel as a fragment on a valid/ready stream.
module tile_pixel_walker
    import raster_pkg::*;
#(
    parameter int COORD_W = DEF_COORD_W,
    parameter int EDGE_W  = DEF_EDGE_W,
    parameter int T       = 16
) (
    input  logic                clk,
    input  logic                rst,
    tile_pixel_walker_if.slave  bus,
    output walk_state_e         state_o
);
    localparam int            PW     = $clog2(T);
    localparam logic [PW-1:0] P_LAST = PW'(T - 1);

    walk_state_e               state_q, state_d;
    logic [PW-1:0]             px_q, px_d, py_q, py_d;
    logic [COORD_W-1:0]        tx_q, tx_d, ty_q, ty_d;
    logic                      fv_q, fv_d, done_q, done_d;
    logic [COORD_W-1:0]        fx_q, fx_d, fy_q, fy_d;
    logic [2:0][EDGE_W-1:0]    fw_q, fw_d;
    logic [2:0][EDGE_W-1:0]    e_in, a_in, b_in, cur;
    logic                      load, step_x, step_row, stall;

    assign e_in = {bus.e2, bus.e1, bus.e0};
    assign a_in = {sext_coeff(bus.a2), sext_coeff(bus.a1), sext_coeff(bus.a0)};
    assign b_in = {sext_coeff(bus.b2), sext_coeff(bus.b1), sext_coeff(bus.b0)};

    for (genvar i = 0; i < 3; i++) begin : g_edge
        edge_stepper #(.EDGE_W(EDGE_W)) u_step (
            .clk        (clk),
            .rst        (rst),
            .load_i     (load),
            .step_x_i   (step_x),
            .step_row_i (step_row),
            .e_i        (e_in[i]),
            .a_i        (a_in[i]),
            .b_i        (b_in[i]),
            .cur_o      (cur[i])
        );
    end

    // A fragment that is presented but not taken freezes the whole walk.
    assign stall = fv_q && !bus.frag_ready;

    always_comb begin
        state_d  = state_q;
        px_d     = px_q;
        py_d     = py_q;
        tx_d     = tx_q;
        ty_d     = ty_q;
        fv_d     = fv_q;
        fx_d     = fx_q;
        fy_d     = fy_q;
        fw_d     = fw_q;
        done_d   = 1'b0;
        load     = 1'b0;
        step_x   = 1'b0;
        step_row = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.tile_valid) begin
                    tx_d = bus.tile_x;
                    ty_d = bus.tile_y;
                    if (bus.tile_inside) begin
                        px_d    = '0;
                        py_d    = '0;
                        load    = 1'b1;
                        state_d = ST_SCAN;
                    end else begin
                        state_d = ST_FINISH;
                    end
                end
            end
            ST_SCAN: begin
                if (!stall) begin
                    fv_d = is_inside(cur[0], cur[1], cur[2]);
                    fx_d = tx_q + COORD_W'(px_q);
                    fy_d = ty_q + COORD_W'(py_q);
                    fw_d = cur;
                    if (px_q != P_LAST) begin
                        px_d   = px_q + PW'(1);
                        step_x = 1'b1;
                    end else begin
                        px_d     = '0;
                        py_d     = py_q + PW'(1);
                        step_row = 1'b1;
                        if (py_q == P_LAST) begin
                            state_d = ST_FINISH;
                        end
                    end
                end
            end
            ST_FINISH: begin
                // Done only once the final fragment (if any) has left.
                if (!fv_q || bus.frag_ready) begin
                    fv_d    = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            px_q    <= '0;
            py_q    <= '0;
            tx_q    <= '0;
            ty_q    <= '0;
            fv_q    <= 1'b0;
            fx_q    <= '0;
            fy_q    <= '0;
            fw_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            px_q    <= px_d;
            py_q    <= py_d;
            tx_q    <= tx_d;
            ty_q    <= ty_d;
            fv_q    <= fv_d;
            fx_q    <= fx_d;
            fy_q    <= fy_d;
            fw_q    <= fw_d;
            done_q  <= done_d;
        end
    end

    assign bus.tile_ready = (state_q == ST_IDLE);
    assign bus.frag_valid = fv_q;
    assign bus.frag_x     = fx_q;
    assign bus.frag_y     = fy_q;
    assign bus.frag_w0    = fw_q[0];
    assign bus.frag_w1    = fw_q[1];
    assign bus.frag_w2    = fw_q[2];
    assign bus.tile_done  = done_q;
    assign state_o        = state_q;
endmodule

// File: doc/tile_pixel_walker.md
# tile_pixel_walker

Per-pixel traversal stage placed directly downstream of `edge_function_evaluator`. It accepts one evaluated tile: origin coordinates, the three edge values at the tile origin, the X/Y edge coefficients, and the tile-inside flag. It walks the T×T pixels of that tile in raster order, one pixel per cycle, by incremental addition. Every pixel whose three edge values are all non-negative is emitted as a fragment on a valid/ready stream toward the fragment/shading stage.

## Interface
- `COORD_W`, 10, screen coordinate width.
- `COEFF_W`, 16, edge coefficient width, signed two's complement.
- `EDGE_W`, 32, edge value width, signed two's complement.
- `T`, 16, tile edge length in pixels; must be a power of two, ≥ 2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `tile_valid`  in  1  upstream tile descriptor valid.
- `tile_ready`  out  1  walker can accept a tile; equals (state == IDLE).
- `tile_inside`  in  1  0 means the tile is rejected without being walked.
- `tile_x`, `tile_y`  in  COORD_W  tile origin pixel.
- `e0`, `e1`, `e2`  in  EDGE_W  edge values at (tile_x, tile_y).
- `a0`, `b0`, `a1`, `b1`, `a2`, `b2`  in  COEFF_W  per-edge increments for +1 x and +1 y.
- `frag_valid`  out  1  fragment valid.
- `frag_ready`  in  1  downstream accepts fragment.
- `frag_x`, `frag_y`  out  COORD_W  fragment pixel coordinates.
- `frag_w0`, `frag_w1`, `frag_w2`  out  EDGE_W  edge values at the fragment (barycentric weights, unnormalised).
- `tile_done`  out  1  one-cycle pulse; the tile is fully processed and its last fragment has been consumed.

## Operation
- States: IDLE, SCAN, FINISH.
- IDLE: on `tile_valid && tile_ready`, capture all tile inputs.
  - If `tile_inside` = 1, set px = py = 0, set row and cur accumulators to e0..e2, and go to SCAN.
  - Otherwise go to FINISH.
- SCAN: the stall condition is `frag_valid && !frag_ready`. When stalled, nothing advances.
- SCAN, when not stalled, at each edge:
  - Evaluate the current pixel. Set `frag_valid` to (cur0 ≥ 0 && cur1 ≥ 0 && cur2 ≥ 0), signed comparison.
  - Load `frag_x` = tile_x + px and `frag_y` = tile_y + py, both mod 2^COORD_W. Load `frag_w*` with the cur values.
  - Advance the position. If px < T−1: px++ and cur += a. Otherwise: px = 0, py++, row += b, and cur takes the new row value.
  - After evaluating pixel (T−1, T−1), go to FINISH.
- FINISH: wait until `!frag_valid || frag_ready`. On that edge, clear `frag_valid`, set `tile_done` for one cycle, and go to IDLE.
- Arithmetic:
  - Coefficients are sign-extended to EDGE_W.
  - All accumulation is modulo 2^EDGE_W, with no saturation.
  - px and py are log2(T) bits wide.
- Outputs on reset and during reset:
  - `frag_valid` = 0, `tile_done` = 0.
  - `frag_x`, `frag_y`, `frag_w*` = 0.
  - State is IDLE, so `tile_ready` = 1.
- Reset asserted mid-walk abandons the tile. No `tile_done` is produced for it.

## Timing
- Tile accepted at edge N:
  - Pixel k (k = py·T + px) is evaluated at edge N+1+k when there are no stalls. The fragment is visible from that edge until it is consumed.
- Unstalled, fully covered tile:
  - FINISH exits at edge N+T²+1, and `tile_done` is high for the following cycle.
  - `tile_ready` is high again after edge N+T²+1, so the next tile can be accepted at edge N+T²+2.
- Rejected tile: FINISH exits at edge N+1, so `tile_done` pulses in the cycle after edge N+1.
- Throughput and stability:
  - The walker sustains one pixel per cycle when `frag_ready` = 1.
  - Fragment outputs stay stable while `frag_valid && !frag_ready`.
- `tile_done` and `tile_ready` are both high in the cycle after FINISH exits.
- The walker does not depend on upstream holding the tile inputs after acceptance.

## Structure
- Shared package `raster_pkg`:
  - state encoding (IDLE, SCAN, FINISH);
  - `EDGE_W` default;
  - sign-extension function from COEFF_W to EDGE_W;
  - inside-test function (three signed ≥ 0 comparisons).
- Sub-module `edge_stepper`, instantiated three times, one per edge.
  - It holds the row and cur accumulators.
  - Control inputs: load, step_x, step_row.
  - Data inputs: e, a, b.
  - Output: cur.

## Test plan
- Half-plane x ≥ 5: tile (32,48), e0 = −5, a0 = 1, b0 = 0, e1 = e2 = 100, other coefficients 0, `frag_ready` = 1 → exactly 176 fragments (x = 37..47 on every row y = 48..63). First fragment is (37,48) with w0 = 0; last is (47,63) with w0 = 10; `tile_done` pulses once.
- Full coverage: e = 0, a = b = 0 → 256 consecutive fragments at one per cycle; `tile_done` in the cycle after edge N+257.
- Rejected tile: `tile_inside` = 0 → zero fragments, `tile_done` in the cycle after edge N+1, `tile_ready` high again.
- Backpressure: full-coverage tile, `frag_ready` low for 10 cycles at fragment 40 → `frag_valid`, `frag_x`/`frag_y` and `frag_w*` held stable; still 256 fragments in order with none duplicated; `tile_done` delayed by exactly 10 cycles.
- Negative step and wrap:
  - Stimulus: tile_x = 1016, tile_y = 0, e0 = 3, a0 = −1, b0 = −16, e1 = e2 = 1.
  - Required: fragments only on row y = 0, at x = 1016..1019; coordinate wrap is checked with tile_x = 1020, which gives frag_x = 1020..1023 and wraps to 0 for px = 4 when coverage is widened.
- Reset mid-walk: `rst` low at fragment 100 → `frag_valid` and `tile_done` are 0 immediately; after release `tile_ready` = 1 and a new tile walks correctly from pixel (0,0).
